// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between core and
// the iterative RV32M multiply/divide unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_sel_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_sel_out;

  modport master (
    output start, funct3,
    output rs1_data, rs2_data,
    output rd_sel_in,
    input  busy, done,
    input  result, rd_sel_out
  );

  modport slave (
    input  start, funct3,
    input  rs1_data, rs2_data,
    input  rd_sel_in,
    output busy, done,
    output result, rd_sel_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: fixed-latency iterative RV32M mul/div.
// Shift-add multiply, restoring divide, sign fix-up.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  io
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic              r_sa;
  logic              r_sb;
  logic              r_ovf;
  logic [4:0]        r_cnt;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN:0]     r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd;

  logic              w_accept;
  logic              w_busy;
  logic              w_done;
  logic              w_sgn_a;
  logic              w_sgn_b;
  logic              w_neg_a;
  logic              w_neg_b;
  logic              w_ovf;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN:0]     w_add;
  logic [2*XLEN-1:0] w_prod_nx;
  logic [XLEN+1:0]   w_sh;
  logic [XLEN+1:0]   w_sub;
  logic              w_ge;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s;
  logic [XLEN-1:0]   w_rem_s;
  logic [XLEN-1:0]   w_a_orig;
  logic [XLEN-1:0]   w_fix;

  assign w_accept = (r_state == S_IDLE) && io.start;

  // operand signedness from funct3
  always_comb begin
    w_sgn_a = 1'b0;
    w_sgn_b = 1'b0;
    case (io.funct3)
      3'b001, 3'b100, 3'b110: begin
        w_sgn_a = 1'b1;
        w_sgn_b = 1'b1;
      end
      3'b010: w_sgn_a = 1'b1;
      default: ;
    endcase
  end

  assign w_neg_a = w_sgn_a & io.rs1_data[XLEN-1];
  assign w_neg_b = w_sgn_b & io.rs2_data[XLEN-1];
  assign w_mag_a = w_neg_a ? -io.rs1_data : io.rs1_data;
  assign w_mag_b = w_neg_b ? -io.rs2_data : io.rs2_data;

  assign w_ovf = ((io.funct3 == 3'b100) ||
                  (io.funct3 == 3'b110)) &&
                 (io.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (io.rs2_data == {XLEN{1'b1}});

  // multiplier bit in prod[0]; add-then-shift
  assign w_add = {1'b0, r_prod[2*XLEN-1:XLEN]} +
                 (r_prod[0] ? {1'b0, r_a} : '0);
  assign w_prod_nx = {w_add, r_prod[XLEN-1:1]};

  // dividend bits shift out of r_quo into remainder
  assign w_sh  = {r_rem, r_quo[XLEN-1]};
  assign w_sub = w_sh - {2'b00, r_b};
  assign w_ge  = ~w_sub[XLEN+1];

  assign w_prod_s = (r_sa ^ r_sb) ? -r_prod : r_prod;
  assign w_quo_s  = (r_sa ^ r_sb) ? -r_quo : r_quo;
  assign w_rem_s  = r_sa ? -r_rem[XLEN-1:0]
                         : r_rem[XLEN-1:0];
  assign w_a_orig = r_sa ? -r_a : r_a;

  // result select plus div-by-zero / overflow overrides
  always_comb begin
    w_fix = '0;
    case (r_op)
      3'b000:                 w_fix = w_prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix = w_prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix = w_quo_s;
      default:                w_fix = w_rem_s;
    endcase
    if (r_op[2] && (r_b == '0)) begin
      w_fix = r_op[1] ? w_a_orig : '1;
    end else if (r_ovf) begin
      w_fix = r_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // next state and status outputs
  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_IDLE: if (io.start) w_next = S_CALC;
      S_CALC: begin
        w_busy = 1'b1;
        if (r_cnt == 5'd0) w_next = S_FIX;
      end
      S_FIX: begin
        w_busy = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
    endcase
  end

  // operand latch, iteration and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_result <= '0;
      r_rd     <= '0;
    end else if (w_accept) begin
      r_op   <= io.funct3;
      r_a    <= w_mag_a;
      r_b    <= w_mag_b;
      r_sa   <= w_neg_a;
      r_sb   <= w_neg_b;
      r_ovf  <= w_ovf;
      r_cnt  <= 5'd31;
      r_prod <= {{XLEN{1'b0}}, w_mag_b};
      r_rem  <= '0;
      r_quo  <= w_mag_a;
      r_rd   <= io.rd_sel_in;
    end else if (r_state == S_CALC) begin
      r_cnt  <= r_cnt - 5'd1;
      r_prod <= w_prod_nx;
      r_rem  <= w_ge ? w_sub[XLEN:0] : w_sh[XLEN:0];
      r_quo  <= {r_quo[XLEN-2:0], w_ge};
    end else if (r_state == S_FIX) begin
      r_result <= w_fix;
    end
  end

  assign io.busy       = w_busy;
  assign io.done       = w_done;
  assign io.result     = r_result;
  assign io.rd_sel_out = r_rd;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit.
// Checks values, latency, interference and async reset.
module tb_muldiv_unit;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h",
               tag, got, exp);
    end
  endtask

  task automatic no_done(input string tag, input int cyc);
    int hits;
    hits = 0;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk); #1;
      if (bus.done) hits++;
    end
    check(tag, hits, 0);
  endtask

  task automatic run_op(
    input string       tag,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  rd,
    input logic [31:0] exp,
    input bit          disturb
  );
    int n;
    bit seen;
    @(negedge clk);
    bus.funct3    = f3;
    bus.rs1_data  = a;
    bus.rs2_data  = b;
    bus.rd_sel_in = rd;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_busy"}, bus.busy, 1);
    n    = 1;
    seen = 1'b0;
    while (n <= 40 && !seen) begin
      if (disturb && n >= 5 && n <= 15) begin
        bus.start     = 1'b1;
        bus.rs1_data  = $urandom;
        bus.rs2_data  = $urandom;
        bus.rd_sel_in = ~rd;
        bus.funct3    = ~f3;
      end
      if (disturb && n == 16) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
      else n++;
    end
    check({tag, "_lat"}, n, 33);
    check({tag, "_res"}, bus.result, exp);
    check({tag, "_rd"}, bus.rd_sel_out, rd);
    @(posedge clk); #1;
    check({tag, "_width"}, bus.done, 0);
    if (disturb) no_done({tag, "_extra"}, 40);
  endtask

  initial begin
    int n;
    int m;
    n_chk  = 0;
    n_fail = 0;
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.funct3    = 3'b000;
    bus.rs1_data  = '0;
    bus.rs2_data  = '0;
    bus.rd_sel_in = '0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_res", bus.result, 0);
    check("rst_rd", bus.rd_sel_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op("mul", 3'b000, 32'd7, 32'hFFFFFFFD,
           5'd9, 32'hFFFFFFEB, 1'b0);
    run_op("mulh", 3'b001, 32'h80000000, 32'h80000000,
           5'd1, 32'h40000000, 1'b0);
    run_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF,
           5'd2, 32'hFFFFFFFE, 1'b0);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF,
           5'd3, 32'hFFFFFFFF, 1'b0);
    run_op("div", 3'b100, 32'hFFFFFFF9, 32'd2,
           5'd4, 32'hFFFFFFFD, 1'b0);
    run_op("rem", 3'b110, 32'hFFFFFFF9, 32'd2,
           5'd5, 32'hFFFFFFFF, 1'b0);
    run_op("divu", 3'b101, 32'hFFFFFFF9, 32'd2,
           5'd6, 32'h7FFFFFFC, 1'b0);
    run_op("remu", 3'b111, 32'hFFFFFFF9, 32'd2,
           5'd7, 32'h00000001, 1'b0);
    run_op("divu0", 3'b101, 32'h1234, 32'd0,
           5'd8, 32'hFFFFFFFF, 1'b0);
    run_op("remu0", 3'b111, 32'h1234, 32'd0,
           5'd10, 32'h00001234, 1'b0);
    run_op("div0", 3'b100, 32'hFFFFFFF9, 32'd0,
           5'd11, 32'hFFFFFFFF, 1'b0);
    run_op("rem0", 3'b110, 32'hFFFFFFF9, 32'd0,
           5'd12, 32'hFFFFFFF9, 1'b0);
    run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF,
           5'd13, 32'h80000000, 1'b0);
    run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF,
           5'd14, 32'h00000000, 1'b0);
    run_op("dist", 3'b000, 32'd1000, 32'd1000,
           5'd21, 32'd1000000, 1'b1);

    // start held high: back-to-back ops every 35 cycles
    @(negedge clk);
    bus.funct3    = 3'b000;
    bus.rs1_data  = 32'd6;
    bus.rs2_data  = 32'd7;
    bus.rd_sel_in = 5'd17;
    bus.start     = 1'b1;
    n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("held_first", bus.done, 1);
    check("held_res", bus.result, 32'd42);
    m = 0;
    do begin
      @(posedge clk); #1;
      m++;
    end while (!bus.done && m < 50);
    check("held_period", m, 35);
    bus.start = 1'b0;
    repeat (40) @(posedge clk);

    // async reset in the middle of CALC
    @(negedge clk);
    bus.funct3    = 3'b001;
    bus.rs1_data  = 32'h12345678;
    bus.rs2_data  = 32'h9ABCDEF0;
    bus.rd_sel_in = 5'd30;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_res", bus.result, 0);
    check("arst_rd", bus.rd_sel_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    no_done("arst_nodone", 40);
    run_op("post_rst", 3'b000, 32'd3, 32'd5,
           5'd15, 32'd15, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
